envelope_stream_sink: RTL
=========================

# envelope_stream_sink

AXI-Stream sink that terminates the envelope chain (Hilbert FIR → |·| → decimating FIR) and buffers a fixed-length frame of 32-bit signed envelope samples for the RISC-V core to read. The core arms a capture, the block fills an internal FIFO from the stream, flags frame completion and serves pops through a simple read port. Outside a capture the stream is drained and discarded, so the upstream FIRs never stall.

## Interface
- DATA_W, 32, sample width (signed, two's complement, passed through unmodified)
- DEPTH, 64, FIFO entries; power of two, ≥ 4
- FRAME_LEN, 320, samples per capture; 1 ≤ FRAME_LEN ≤ 65535
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- s_axis_data_tdata  in  DATA_W  envelope sample
- s_axis_data_tvalid  in  1  sample valid
- s_axis_data_tready  out  1  sink ready
- start  in  1  one-cycle pulse: flush FIFO and arm a new capture
- rd_en  in  1  pop request
- rd_data  out  DATA_W  popped sample, registered
- rd_valid  out  1  rd_data valid this cycle
- level  out  log2(DEPTH)+1  FIFO occupancy
- busy  out  1  high in CAPTURE
- frame_done  out  1  level-high in DONE
- done_pulse  out  1  one cycle on CAPTURE→DONE
- overflow  out  1  sticky, cleared by start or RST

## Operation
- FSM states: IDLE, CAPTURE, DONE. RST → IDLE.
- IDLE: tready=1, accepted samples discarded. start → CAPTURE.
- CAPTURE: tready = !full (registered full flag). Transfer = tvalid & tready writes tdata to FIFO, increments 16-bit sample counter. Transfer that makes counter == FRAME_LEN → DONE next edge, done_pulse high for that one cycle.
- DONE: tready=1, samples discarded; FIFO contents preserved until popped. start → CAPTURE.
- start in any state (incl. mid-capture): FIFO pointers and counter cleared, overflow cleared, state → CAPTURE; a transfer coinciding with start is discarded.
- Read: rd_en with level>0 → rd_data = head, rd_valid=1 next cycle, level decremented on the same edge. rd_en with level==0 → ignored, rd_valid=0 next cycle, rd_data holds.
- Pops allowed in every state, concurrently with capture.
- Simultaneous push and pop: full → pop only (tready already 0); empty → push only (pop ignored); otherwise both, level unchanged.
- Pointers log2(DEPTH) bits, wrap modulo DEPTH; full = level==DEPTH, empty = level==0.

## Timing
- Reset values: s_axis_data_tready=1, rd_data=0, rd_valid=0, level=0, busy=0, frame_done=0, done_pulse=0, overflow=0.
- Push latency: sample accepted at edge N is counted in level after edge N and poppable from cycle N+1.
- Pop latency: rd_en sampled at edge N → rd_data/rd_valid valid after edge N for one cycle.
- tready depends only on registered state; no combinational path tvalid→tready or rd_en→tready. Space freed by a pop at edge N raises tready after edge N.
- busy/frame_done change on the edge of the state transition; done_pulse coincident with first frame_done cycle.

## Configuration
- ENV_SINK_DROP_EN defined: in CAPTURE tready held 1 (for upstream that ignores backpressure); transfer while full is dropped, still counted toward FRAME_LEN, and sets overflow.
- Not defined: backpressure as above; overflow stays 0.

## Test plan
- RST then start, stream 0..FRAME_LEN-1 (FRAME_LEN=8, DEPTH=16) back-to-back → level=8, done_pulse once on 8th transfer, 8 pops return 0..7 in order, then rd_en on empty → rd_valid=0.
- FRAME_LEN=32, DEPTH=16, no pops → tready drops after 16th transfer, stream stalls; pop 1 → tready high next cycle, exactly one more sample accepted.
- Same with ENV_SINK_DROP_EN → tready stays 1, samples 16..31 dropped, overflow=1, DONE reached after 32 transfers, pops return 0..15.
- Level at 15 of 16, push and pop same cycle for 20 cycles with values 0x8000_0000, 0x7FFF_FFFF alternating → level stays 15, popped data bit-exact, pointer wrap correct.
- start after 5 of 8 samples → level=0, overflow cleared, next 8 samples → DONE with exactly those 8.
- Stream in IDLE/DONE (1000 samples) → tready=1 throughout, level unchanged, no done_pulse.

Source files
------------

// File: rtl/envelope_stream_sink.sv
// Envelope-chain AXI-Stream sink: captures FRAME_LEN samples into a FIFO for the core to pop.
// Optional macro ENV_SINK_DROP_EN: never backpressure in CAPTURE; drop on full and flag overflow.
module envelope_stream_sink #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int FRAME_LEN = 320
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_W-1:0]        s_axis_data_tdata,
  input  logic                     s_axis_data_tvalid,
  output logic                     s_axis_data_tready,
  input  logic                     start,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     done_pulse,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0]   LAST_CNT = 16'(FRAME_LEN - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;
  logic [15:0]       cnt_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q, busy_q, frame_done_q, done_pulse_q, overflow_q;

  logic full, cap_xfer, push, pop, last;

  // tready is a function of registered state only
  assign full = (level_q == FULL_LVL);
`ifdef ENV_SINK_DROP_EN
  assign s_axis_data_tready = 1'b1;
`else
  assign s_axis_data_tready = !((state_q == CAPTURE) && full);
`endif

  assign cap_xfer = s_axis_data_tvalid && s_axis_data_tready && (state_q == CAPTURE) && !start;
  assign push     = cap_xfer && !full;
  assign pop      = rd_en && (level_q != '0);
  assign last     = cap_xfer && (cnt_q == LAST_CNT);

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_data_tdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      done_pulse_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rd_valid_q   <= pop;
      done_pulse_q <= 1'b0;
      if (pop) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      if (start) begin
        // flush wins over any concurrent push/pop bookkeeping
        state_q      <= CAPTURE;
        busy_q       <= 1'b1;
        frame_done_q <= 1'b0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        level_q      <= '0;
        cnt_q        <= '0;
        overflow_q   <= 1'b0;
      end else begin
        level_q <= level_d;
        if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
        if (cap_xfer) cnt_q    <= cnt_q + 1'b1;
`ifdef ENV_SINK_DROP_EN
        if (cap_xfer && full) overflow_q <= 1'b1;
`endif
        if (last) begin
          state_q      <= DONE;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
          done_pulse_q <= 1'b1;
        end
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign level      = level_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign done_pulse = done_pulse_q;
  assign overflow   = overflow_q;
endmodule
